// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS-15 link test: run states, LED status codes
// and the default pattern width / frame count used by generator, detector and sequencer.
package prbs_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StLoad  = 3'd2,
        StRun   = 3'd3,
        StPass  = 3'd4,
        StFail  = 3'd5
    } state_e;

    localparam logic [3:0] STATUS_PASS = 4'b0101;
    localparam logic [3:0] STATUS_FAIL = 4'b1010;
    localparam logic [3:0] STATUS_NONE = 4'b0000;

    localparam int unsigned DEF_PATTERN_W = 32;
    localparam int unsigned DEF_N_FRAMES  = 2;

endpackage

// File: rtl/prbs_run_timer.sv
// RUN-phase bit counter: synchronous clear, count enable, saturation at all-ones,
// timeout terminal-count compare and minimum-run (early-detect limit) compare.
module prbs_run_timer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned MIN_CNT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o,
    output logic             min_ok_o
);

    localparam logic [CNT_W-1:0] TcVal  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MinVal = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MaxVal = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign tc_o     = (cnt_q == TcVal);
    assign min_ok_o = (cnt_q >= MinVal);

endmodule

// File: rtl/prbs_test_ctrl.sv
// Run-level sequencer for the PRBS-15 link test: CLEAR -> LOAD -> RUN -> PASS/FAIL,
// with abort, early-detect and timeout handling. All outputs are registered.
// Optional build macro PRBS_CTRL_STATS_EN adds saturating pass/fail run counters;
// without it pass_cnt and fail_cnt are tied to zero.
module prbs_test_ctrl
    import prbs_pkg::*;
#(
    parameter int unsigned PATTERN_W = DEF_PATTERN_W,
    parameter int unsigned N_FRAMES  = DEF_N_FRAMES,
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PATTERN_W-1:0] pattern,
    output logic [PATTERN_W-1:0] gen_pattern,
    output logic                 gen_load,
    output logic                 gen_en,
    output logic                 det_clr,
    input  logic                 det_done,
    output logic                 busy,
    output logic                 pass,
    output logic                 fail,
    output logic [3:0]           status,
    output logic [CNT_W-1:0]     bit_cnt,
    output logic [7:0]           pass_cnt,
    output logic [7:0]           fail_cnt
);

    localparam logic [3:0] ClrLast = 4'(CLR_CYC - 1);

    state_e state_q, state_d;
    logic [3:0] clr_cnt_q, clr_cnt_d;

    logic [PATTERN_W-1:0] gen_pattern_q;
    logic gen_load_q, gen_en_q, det_clr_q, busy_q, pass_q, fail_q;
    logic [3:0] status_q;

    logic start_acc;
    logic run_en;
    logic tc, min_ok;

    // A start is taken only when not busy and not overridden by abort.
    assign start_acc = start && !abort &&
                       ((state_q == StIdle) || (state_q == StPass) || (state_q == StFail));
    // Count only cycles that stay in RUN, so the final value is the one that decided.
    assign run_en    = (state_q == StRun) && (state_d == StRun);

    // Next-state decode: abort first, then per-state transitions; done beats timeout.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StPass, StFail: begin
                    if (start) state_d = StClear;
                end
                StClear: begin
                    if (clr_cnt_q == ClrLast) state_d = StLoad;
                end
                StLoad: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (det_done) begin
                        state_d = min_ok ? StPass : StFail;
                    end else if (tc) begin
                        state_d = StFail;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Clear-phase cycle counter restarts on every entry to CLEAR.
    always_comb begin
        clr_cnt_d = 4'd0;
        if ((state_q == StClear) && (state_d == StClear)) begin
            clr_cnt_d = clr_cnt_q + 4'd1;
        end
    end

    // State and clear counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            clr_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Output registers decoded from the next state, so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_pattern_q <= '0;
            gen_load_q    <= 1'b0;
            gen_en_q      <= 1'b0;
            det_clr_q     <= 1'b0;
            busy_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            status_q      <= STATUS_NONE;
        end else begin
            if (start_acc) gen_pattern_q <= pattern;
            gen_load_q <= (state_d == StLoad);
            gen_en_q   <= (state_d == StRun);
            det_clr_q  <= (state_d == StClear);
            busy_q     <= (state_d == StClear) || (state_d == StLoad) || (state_d == StRun);
            pass_q     <= (state_d == StPass);
            fail_q     <= (state_d == StFail);
            status_q   <= (state_d == StPass) ? STATUS_PASS :
                          (state_d == StFail) ? STATUS_FAIL : STATUS_NONE;
        end
    end

    prbs_run_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .MIN_CNT (PATTERN_W * N_FRAMES)
    ) u_run_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_acc),
        .en_i     (run_en),
        .cnt_o    (bit_cnt),
        .tc_o     (tc),
        .min_ok_o (min_ok)
    );

`ifdef PRBS_CTRL_STATS_EN
    logic [7:0] pass_cnt_q, fail_cnt_q;

    // Saturating run counters bumped on entry to PASS / FAIL; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= 8'd0;
            fail_cnt_q <= 8'd0;
        end else begin
            if ((state_d == StPass) && (state_q != StPass) && (pass_cnt_q != 8'hff)) begin
                pass_cnt_q <= pass_cnt_q + 8'd1;
            end
            if ((state_d == StFail) && (state_q != StFail) && (fail_cnt_q != 8'hff)) begin
                fail_cnt_q <= fail_cnt_q + 8'd1;
            end
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign pass_cnt = 8'd0;
    assign fail_cnt = 8'd0;
`endif

    assign gen_pattern = gen_pattern_q;
    assign gen_load    = gen_load_q;
    assign gen_en      = gen_en_q;
    assign det_clr     = det_clr_q;
    assign busy        = busy_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign status      = status_q;

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Directed bench for prbs_test_ctrl with default parameters (limit 64, timeout 4096).
module tb_prbs_test_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] pattern = 32'h0;
    logic [31:0] gen_pattern;
    logic        gen_load, gen_en, det_clr;
    logic        det_done = 1'b0;
    logic        busy, pass, fail;
    logic [3:0]  status;
    logic [15:0] bit_cnt;
    logic [7:0]  pass_cnt, fail_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prbs_test_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .gen_pattern (gen_pattern),
        .gen_load    (gen_load),
        .gen_en      (gen_en),
        .det_clr     (det_clr),
        .det_done    (det_done),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .status      (status),
        .bit_cnt     (bit_cnt),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and advance to the first RUN cycle (bit_cnt 0).
    task automatic begin_run(input logic [31:0] pat);
        pattern = pat;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Pulse det_done once bit_cnt has reached n.
    task automatic done_at(input int n);
        repeat (n) tick();
        det_done = 1'b1;
        tick();
        det_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b want 0", fail); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", status); end
        checks++; if ({gen_en, gen_load, det_clr} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {gen_en, gen_load, det_clr}); end
        checks++; if (gen_pattern !== 32'h0) begin errors++; $display("FAIL reset_pattern got %h want 0", gen_pattern); end
        checks++; if (bit_cnt !== 16'd0) begin errors++; $display("FAIL reset_bitcnt got %0d want 0", bit_cnt); end
        // det_done while idle must not start or end anything
        det_done = 1'b1;
        tick();
        tick();
        det_done = 1'b0;
        checks++; if ({busy, pass, fail} !== 3'b000) begin errors++; $display("FAIL idle_done_ignored got %b want 000", {busy, pass, fail}); end
    endtask

    task automatic test_normal_pass();
        pattern = 32'hA5C3_0FF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (det_clr !== 1'b1) begin errors++; $display("FAIL clr_cyc1 got %b want 1", det_clr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_cyc1 got %b want 1", busy); end
        checks++; if (gen_pattern !== 32'hA5C3_0FF0) begin errors++; $display("FAIL latch_pattern got %h want a5c30ff0", gen_pattern); end
        tick();
        checks++; if ({det_clr, gen_load} !== 2'b10) begin errors++; $display("FAIL clr_cyc2 got %b want 10", {det_clr, gen_load}); end
        tick();
        checks++; if ({det_clr, gen_load, gen_en} !== 3'b010) begin errors++; $display("FAIL load_cyc3 got %b want 010", {det_clr, gen_load, gen_en}); end
        tick();
        checks++; if ({gen_load, gen_en} !== 2'b01) begin errors++; $display("FAIL run_cyc4 got %b want 01", {gen_load, gen_en}); end
        checks++; if (bit_cnt !== 16'd0) begin errors++; $display("FAIL run_start_cnt got %0d want 0", bit_cnt); end
        repeat (70) tick();
        checks++; if (bit_cnt !== 16'd70) begin errors++; $display("FAIL run_cnt70 got %0d want 70", bit_cnt); end
        det_done = 1'b1;
        tick();
        det_done = 1'b0;
        checks++; if ({pass, fail} !== 2'b10) begin errors++; $display("FAIL pass_flags got %b want 10", {pass, fail}); end
        checks++; if (status !== 4'b0101) begin errors++; $display("FAIL pass_status got %b want 0101", status); end
        checks++; if ({gen_en, busy} !== 2'b00) begin errors++; $display("FAIL pass_idle_out got %b want 00", {gen_en, busy}); end
        repeat (3) tick();
        checks++; if (bit_cnt !== 16'd70) begin errors++; $display("FAIL pass_frozen got %0d want 70", bit_cnt); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_sticky got %b want 1", pass); end
    endtask

    task automatic test_limit_boundary();
        begin_run(32'h0F0F_0F0F);
        done_at(64);
        checks++; if ({pass, fail} !== 2'b10) begin errors++; $display("FAIL done_at_64 got %b want 10", {pass, fail}); end
        begin_run(32'h0F0F_0F0F);
        done_at(63);
        checks++; if ({pass, fail} !== 2'b01) begin errors++; $display("FAIL done_at_63 got %b want 01", {pass, fail}); end
    endtask

    task automatic test_early_detect_restart();
        begin_run(32'hCAFE_F00D);
        done_at(10);
        checks++; if ({pass, fail} !== 2'b01) begin errors++; $display("FAIL early_flags got %b want 01", {pass, fail}); end
        checks++; if (status !== 4'b1010) begin errors++; $display("FAIL early_status got %b want 1010", status); end
        checks++; if (bit_cnt !== 16'd10) begin errors++; $display("FAIL early_cnt got %0d want 10", bit_cnt); end
        // restart straight from FAIL with a new pattern
        pattern = 32'h1234_5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({fail, det_clr, busy} !== 3'b011) begin errors++; $display("FAIL restart_flags got %b want 011", {fail, det_clr, busy}); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL restart_status got %b want 0000", status); end
        checks++; if (gen_pattern !== 32'h1234_5678) begin errors++; $display("FAIL restart_pattern got %h want 12345678", gen_pattern); end
        checks++; if (bit_cnt !== 16'd0) begin errors++; $display("FAIL restart_cnt got %0d want 0", bit_cnt); end
        tick();
        tick();
        checks++; if (gen_load !== 1'b1) begin errors++; $display("FAIL restart_load got %b want 1", gen_load); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_timeout();
        begin_run(32'h5555_AAAA);
        repeat (4095) tick();
        checks++; if (bit_cnt !== 16'd4095) begin errors++; $display("FAIL to_cnt_4095 got %0d want 4095", bit_cnt); end
        checks++; if ({gen_en, fail} !== 2'b10) begin errors++; $display("FAIL to_not_yet got %b want 10", {gen_en, fail}); end
        tick();
        checks++; if ({pass, fail} !== 2'b01) begin errors++; $display("FAIL to_fail got %b want 01", {pass, fail}); end
        checks++; if (bit_cnt !== 16'd4095) begin errors++; $display("FAIL to_cnt_held got %0d want 4095", bit_cnt); end
        begin_run(32'h5555_AAAA);
        done_at(4095);
        checks++; if ({pass, fail} !== 2'b10) begin errors++; $display("FAIL to_done_wins got %b want 10", {pass, fail}); end
    endtask

    task automatic test_abort();
        begin_run(32'hDEAD_BEEF);
        repeat (5) tick();
        pattern = 32'h1111_1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (gen_pattern !== 32'hDEAD_BEEF) begin errors++; $display("FAIL busy_start_pattern got %h want deadbeef", gen_pattern); end
        checks++; if ({gen_en, det_clr} !== 2'b10) begin errors++; $display("FAIL busy_start_state got %b want 10", {gen_en, det_clr}); end
        checks++; if (bit_cnt !== 16'd6) begin errors++; $display("FAIL busy_start_cnt got %0d want 6", bit_cnt); end
        repeat (14) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({busy, gen_en, det_clr, pass, fail} !== 5'b0) begin errors++; $display("FAIL abort_flags got %b want 00000", {busy, gen_en, det_clr, pass, fail}); end
        checks++; if (bit_cnt !== 16'd20) begin errors++; $display("FAIL abort_cnt_hold got %0d want 20", bit_cnt); end
        // abort and start together out of PASS: abort wins
        begin_run(32'h0000_0001);
        done_at(64);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++; if ({busy, det_clr, pass} !== 3'b000) begin errors++; $display("FAIL abort_wins got %b want 000", {busy, det_clr, pass}); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL abort_status got %b want 0000", status); end
    endtask

    task automatic test_reset_mid_run();
        begin_run(32'h7777_8888);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy, gen_en, gen_load, det_clr} !== 4'b0) begin errors++; $display("FAIL rst_run_flags got %b want 0000", {busy, gen_en, gen_load, det_clr}); end
        checks++; if (bit_cnt !== 16'd0) begin errors++; $display("FAIL rst_run_cnt got %0d want 0", bit_cnt); end
        checks++; if (gen_pattern !== 32'h0) begin errors++; $display("FAIL rst_run_pattern got %h want 0", gen_pattern); end
        // reset during CLEAR leaves no trailing load strobe
        pattern = 32'h9999_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++; if ({det_clr, gen_load, gen_en} !== 3'b000) begin errors++; $display("FAIL rst_clr_strobes got %b want 000", {det_clr, gen_load, gen_en}); end
    endtask

    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef PRBS_CTRL_STATS_EN
        for (int i = 0; i < 3; i++) begin
            begin_run(32'hABCD_0000);
            done_at(64);
        end
        begin_run(32'hABCD_0001);
        done_at(1);
        checks++; if (pass_cnt !== 8'd3) begin errors++; $display("FAIL stats_pass got %0d want 3", pass_cnt); end
        checks++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL stats_fail got %0d want 1", fail_cnt); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({pass_cnt, fail_cnt} !== {8'd3, 8'd1}) begin errors++; $display("FAIL stats_abort got %0d/%0d want 3/1", pass_cnt, fail_cnt); end
        for (int i = 0; i < 300; i++) begin
            begin_run(32'hABCD_0002);
            done_at(64);
        end
        checks++; if (pass_cnt !== 8'd255) begin errors++; $display("FAIL stats_sat got %0d want 255", pass_cnt); end
`else
        begin_run(32'hABCD_0000);
        done_at(64);
        begin_run(32'hABCD_0001);
        done_at(1);
        checks++; if ({pass_cnt, fail_cnt} !== 16'h0) begin errors++; $display("FAIL stats_tied got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_normal_pass();
        test_limit_boundary();
        test_early_detect_restart();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
